// File: rtl/game_sequencer.sv
// Match-level controller for the pong datapath: serve, rally, point and game-over
// sequencing with score keeping, ball gating, sound cues and a status LED.
module game_sequencer #(
  parameter logic [3:0] WINSCORE   = 4'd9,
  parameter int         SERVEDELAY = 64,
  parameter int         POINTDELAY = 32,
  parameter int         FLASHDIV   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       hit,
  output logic       ball_enable,
  output logic       ball_load,
  output logic       serve_dir,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic       beep_req,
  output logic [1:0] beep_tone,
  output logic       led,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int MAXD_SP = (SERVEDELAY > POINTDELAY) ? SERVEDELAY : POINTDELAY;
  localparam int MAXD    = (MAXD_SP > FLASHDIV) ? MAXD_SP : FLASHDIV;
  localparam int CW      = $clog2(MAXD + 1);

  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVEDELAY - 1);
  localparam logic [CW-1:0] POINT_LAST = CW'(POINTDELAY - 1);
  localparam logic [CW-1:0] FLASH_LAST = CW'(FLASHDIV - 1);

  localparam logic [1:0] TONE_HIT   = 2'd1;
  localparam logic [1:0] TONE_POINT = 2'd2;
  localparam logic [1:0] TONE_OVER  = 2'd3;

  state_t          cur_st, nxt_st;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      score_a_n, score_b_n;
  logic            serve_dir_n, beep_req_n, led_n, enter;
  logic            ball_enable_n, ball_load_n;
  logic [1:0]      beep_tone_n;

  assign state = cur_st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_st      <= IDLE;
      cnt         <= '0;
      score_a     <= 4'd0;
      score_b     <= 4'd0;
      serve_dir   <= 1'b1;
      ball_enable <= 1'b0;
      ball_load   <= 1'b0;
      beep_req    <= 1'b0;
      beep_tone   <= 2'd0;
      led         <= 1'b0;
    end else begin
      cur_st      <= nxt_st;
      cnt         <= cnt_n;
      score_a     <= score_a_n;
      score_b     <= score_b_n;
      serve_dir   <= serve_dir_n;
      ball_enable <= ball_enable_n;
      ball_load   <= ball_load_n;
      beep_req    <= beep_req_n;
      beep_tone   <= beep_tone_n;
      led         <= led_n;
    end
  end

  always_comb begin
    nxt_st      = cur_st;
    cnt_n       = cnt;
    score_a_n   = score_a;
    score_b_n   = score_b;
    serve_dir_n = serve_dir;
    beep_req_n  = 1'b0;
    beep_tone_n = beep_tone;
    led_n       = led;
    enter       = 1'b0;

    if (start) begin
      score_a_n   = 4'd0;
      score_b_n   = 4'd0;
      serve_dir_n = 1'b1;
      nxt_st      = SERVE;
      enter       = 1'b1;
    end else begin
      case (cur_st)
        IDLE: begin
          if (frame_tick) begin
            if (cnt == FLASH_LAST) begin
              cnt_n = '0;
              led_n = ~led;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (cnt == SERVE_LAST) begin
              nxt_st = RALLY;
              enter  = 1'b1;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        RALLY: begin
          // A double miss is a void rally: re-serve without scoring or a cue.
          if (miss_left && miss_right) begin
            nxt_st = SERVE;
            enter  = 1'b1;
          end else if (miss_left) begin
            if (score_b < WINSCORE) score_b_n = score_b + 4'd1;
            serve_dir_n = 1'b0;
            beep_req_n  = 1'b1;
            beep_tone_n = TONE_POINT;
            nxt_st      = POINT;
            enter       = 1'b1;
          end else if (miss_right) begin
            if (score_a < WINSCORE) score_a_n = score_a + 4'd1;
            serve_dir_n = 1'b1;
            beep_req_n  = 1'b1;
            beep_tone_n = TONE_POINT;
            nxt_st      = POINT;
            enter       = 1'b1;
          end else if (hit) begin
            beep_req_n  = 1'b1;
            beep_tone_n = TONE_HIT;
          end
        end
        POINT: begin
          if (frame_tick) begin
            if (cnt == POINT_LAST) begin
              enter = 1'b1;
              if (score_a == WINSCORE || score_b == WINSCORE) begin
                nxt_st      = OVER;
                beep_req_n  = 1'b1;
                beep_tone_n = TONE_OVER;
              end else begin
                nxt_st = SERVE;
              end
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        OVER: begin
          nxt_st = OVER;
        end
        default: begin
          nxt_st = IDLE;
          enter  = 1'b1;
        end
      endcase
    end

    // The entry cycle's frame_tick is swallowed by clearing here.
    if (enter) cnt_n = '0;
    if (nxt_st != IDLE) led_n = 1'b1;
    ball_load_n   = enter && (nxt_st == SERVE);
    ball_enable_n = (nxt_st == RALLY);
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: every output-word change is popped by a
// monitor and compared with the hand-computed expectation queued by the driver.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0, miss_left = 1'b0, miss_right = 1'b0, hit = 1'b0;
  logic       ball_enable, ball_load, serve_dir, beep_req, led;
  logic [3:0] score_a, score_b;
  logic [1:0] beep_tone;
  logic [2:0] state;

  localparam int W = 18;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic         mon_en = 1'b0;
  logic [W-1:0] prev_w;

  logic [2:0] e_st;
  logic [3:0] e_sa, e_sb;
  logic       e_dir, e_en, e_ld, e_bq, e_led;
  logic [1:0] e_tone;

  game_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .miss_left(miss_left), .miss_right(miss_right), .hit(hit),
    .ball_enable(ball_enable), .ball_load(ball_load), .serve_dir(serve_dir),
    .score_a(score_a), .score_b(score_b), .beep_req(beep_req),
    .beep_tone(beep_tone), .led(led), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dut_word();
    return {state, score_a, score_b, serve_dir, ball_enable, ball_load,
            beep_req, beep_tone, led};
  endfunction

  task automatic push_exp();
    exp_q.push_back({e_st, e_sa, e_sb, e_dir, e_en, e_ld, e_bq, e_tone, e_led});
  endtask

  task automatic step(input logic rn, input logic ft, input logic st,
                      input logic ml, input logic mr, input logic h);
    @(negedge clk);
    rst_n = rn; frame_tick = ft; start = st; miss_left = ml; miss_right = mr; hit = h;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0);
  endtask

  // n frame ticks spaced by idle cycles; returns right after driving the last.
  task automatic ticks(input int n);
    for (int i = 0; i < n - 1; i++) begin
      step(1, 1, 0, 0, 0, 0);
      idle();
    end
    step(1, 1, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    logic [W-1:0] w, e;
    if (mon_en) begin
      w = dut_word();
      if (w !== prev_w) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_word_unexpected: got %h exp none at %0t", w, $time);
        end else begin
          e = exp_q.pop_front();
          if (w !== e) begin
            bad++;
            $display("FAIL out_word: got %h exp %h at %0t", w, e, $time);
          end
        end
        prev_w = w;
      end
    end
  end

  // Serve delay then release into rally.
  task automatic serve_to_rally();
    ticks(64);
    e_st = 3'd2; e_en = 1; push_exp();
    idle();
  endtask

  initial begin
    e_st = 3'd0; e_sa = 0; e_sb = 0; e_dir = 1; e_en = 0; e_ld = 0;
    e_bq = 0; e_tone = 0; e_led = 0;

    // 1: reset and IDLE flashing
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    total++;
    if (dut_word() !== {e_st, e_sa, e_sb, e_dir, e_en, e_ld, e_bq, e_tone, e_led}) begin
      bad++;
      $display("FAIL reset_word: got %h exp %h", dut_word(),
               {e_st, e_sa, e_sb, e_dir, e_en, e_ld, e_bq, e_tone, e_led});
    end
    prev_w = dut_word();
    mon_en = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 1);
    idle();
    ticks(16);
    e_led = 1; push_exp();
    idle();

    // 2: start, ball_load pulse, serve delay
    step(1, 0, 1, 0, 0, 0);
    e_st = 3'd1; e_ld = 1; push_exp();
    idle();
    e_ld = 0; push_exp();
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    idle();
    serve_to_rally();

    // 3: hit cue, point for A, back to serve
    step(1, 0, 0, 0, 0, 1);
    e_bq = 1; e_tone = 2'd1; push_exp();
    idle();
    e_bq = 0; push_exp();
    step(1, 0, 0, 0, 1, 0);
    e_st = 3'd3; e_sa = 1; e_dir = 1; e_en = 0; e_bq = 1; e_tone = 2'd2; push_exp();
    idle();
    e_bq = 0; push_exp();
    step(1, 0, 0, 1, 0, 1);
    idle();
    ticks(32);
    e_st = 3'd1; e_ld = 1; push_exp();
    idle();
    e_ld = 0; push_exp();
    serve_to_rally();

    // 4: double miss voids the rally
    step(1, 0, 0, 1, 1, 0);
    e_st = 3'd1; e_en = 0; e_ld = 1; push_exp();
    idle();
    e_ld = 0; push_exp();
    serve_to_rally();

    // 5: B scores eight points (first with coincident hit), then the winner
    for (int p = 1; p <= 9; p++) begin
      step(1, 0, 0, 1, 0, (p == 1) ? 1'b1 : 1'b0);
      e_st = 3'd3; e_sb = 4'(p); e_dir = 0; e_en = 0; e_bq = 1; e_tone = 2'd2; push_exp();
      idle();
      e_bq = 0; push_exp();
      ticks(32);
      if (p < 9) begin
        e_st = 3'd1; e_ld = 1; push_exp();
        idle();
        e_ld = 0; push_exp();
        serve_to_rally();
      end
    end
    e_st = 3'd4; e_bq = 1; e_tone = 2'd3; push_exp();
    idle();
    e_bq = 0; push_exp();
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1);
    idle();
    ticks(40);
    idle();
    step(1, 0, 1, 0, 0, 0);
    e_st = 3'd1; e_sa = 0; e_sb = 0; e_dir = 1; e_ld = 1; push_exp();
    idle();
    e_ld = 0; push_exp();
    serve_to_rally();

    // 6: reset mid-rally
    step(0, 0, 0, 0, 0, 0);
    e_st = 3'd0; e_sa = 0; e_sb = 0; e_dir = 1; e_en = 0; e_ld = 0;
    e_bq = 0; e_tone = 0; e_led = 0; push_exp();
    idle();
    idle();
    idle();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL exp_queue_drained: got %0d left exp 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
